// File: rtl/conv55_window_gen.sv
// conv55_window_gen: raster pixel stream to 5x5 valid-convolution windows via four line buffers.
// Optional framing input in_sof / err_sof output enabled by defining CONV55_WINGEN_SOF_EN.
module conv55_window_gen #(
    parameter int DATA_W = 6,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_pixel,
`ifdef CONV55_WINGEN_SOF_EN
    input  logic                  in_sof,
    output logic                  err_sof,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [25*DATA_W-1:0]  out_window,
    output logic                  out_last
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col, ecol;
    logic [RW-1:0] row, erow;
    logic acc, col_end, row_end, emit;
    logic [DATA_W-1:0] lb [4][IMG_W];
    logic [DATA_W-1:0] w  [5][5];
    logic [DATA_W-1:0] nw [5][5];
    logic [DATA_W-1:0] v  [5];
    logic [25*DATA_W-1:0] nw_flat;

    assign in_ready = !out_valid || out_ready;
    assign acc      = in_valid && in_ready;

    // A start-of-frame pixel is processed as if the counters were already at (0,0).
`ifdef CONV55_WINGEN_SOF_EN
    assign ecol = in_sof ? '0 : col;
    assign erow = in_sof ? '0 : row;
`else
    assign ecol = col;
    assign erow = row;
`endif

    assign col_end = ecol == CW'(IMG_W - 1);
    assign row_end = erow == RW'(IMG_H - 1);
    assign emit    = acc && erow >= RW'(4) && ecol >= CW'(4);

    always_comb begin
        for (int r = 0; r < 4; r++) v[r] = lb[r][ecol];
        v[4] = in_pixel;
        nw_flat = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                nw[r][c] = (c == 4) ? v[r] : w[r][c+1];
                nw_flat[DATA_W*(5*r+c) +: DATA_W] = nw[r][c];
            end
        end
    end

    // Line buffers and shift window carry over frames; emission gating hides stale data.
    always_ff @(posedge clk) begin
        if (acc) begin
            for (int r = 0; r < 3; r++) lb[r][ecol] <= lb[r+1][ecol];
            lb[3][ecol] <= in_pixel;
            w <= nw;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_window <= '0;
        end else begin
            if (acc) begin
                col <= col_end ? '0 : ecol + 1'b1;
                row <= col_end ? (row_end ? '0 : erow + 1'b1) : erow;
            end
            if (emit) begin
                out_valid  <= 1'b1;
                out_window <= nw_flat;
                out_last   <= row_end && col_end;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end
        end
    end

`ifdef CONV55_WINGEN_SOF_EN
    logic frame_open;
    logic at_origin;
    assign at_origin = col == '0 && row == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sof    <= 1'b0;
            frame_open <= 1'b0;
        end else begin
            err_sof <= acc && (in_sof ? !at_origin : (at_origin && frame_open));
            if (acc) frame_open <= !(row_end && col_end);
        end
    end
`endif
endmodule

// File: tb/tb_conv55_window_gen.sv
// tb_conv55_window_gen: directed checks of the 5x5 window generator on an 8x6 frame.
module tb_conv55_window_gen;
    localparam int DW = 6;
    localparam int IW = 8;
    localparam int IH = 6;
    localparam int WB = 25 * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [DW-1:0] in_pixel = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [WB-1:0] out_window;
    logic out_last;

    int checks = 0;
    int errors = 0;
    logic [WB-1:0] wq [$];
    bit lq [$];

    conv55_window_gen #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pixel(in_pixel), .out_valid(out_valid), .out_ready(out_ready),
        .out_window(out_window), .out_last(out_last)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!rst && out_valid && out_ready) begin
        wq.push_back(out_window);
        lq.push_back(out_last);
    end

    task automatic chk(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] elem(input logic [WB-1:0] win, input int k);
        return win[DW*k +: DW];
    endfunction

    // Window n of a frame is anchored at pixel (4 + n/4, 4 + n%4); p(r,c) = (8r+c) mod 64.
    function automatic logic [WB-1:0] exp_win(input int n);
        logic [WB-1:0] x;
        int r, c;
        r = 4 + n / 4;
        c = 4 + n % 4;
        x = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                x[DW*(5*i+j) +: DW] = DW'((8 * (r - 4 + i) + (c - 4 + j)) % 64);
        return x;
    endfunction

    task automatic push(input logic [DW-1:0] px, input bit bubble);
        bit hs;
        int n;
        if (bubble) while ($urandom_range(1) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_pixel = px;
        n = 0;
        do begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!hs && n < 200);
        if (!hs) chk("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit bubble);
        for (int i = 0; i < IW * IH; i++) push(DW'(i), bubble);
    endtask

    task automatic drain;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input int base);
        for (int n = 0; n < 8; n++) begin
            chk($sformatf("%s_win%0d", tag, n), wq[base+n], exp_win(n));
            chk($sformatf("%s_last%0d", tag, n), WB'(lq[base+n]), WB'(n == 7));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", WB'(out_valid), 0);
        chk("rst_out_last", WB'(out_last), 0);
        chk("rst_out_window", out_window, 0);
        chk("rst_in_ready", WB'(in_ready), 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic window and first-window latency
        wq.delete(); lq.delete();
        for (int i = 0; i < 36; i++) push(DW'(i), 0);
        chk("pre36_out_valid", WB'(out_valid), 0);
        push(6'd36, 0);
        chk("post36_out_valid", WB'(out_valid), 1);
        chk("first_e0", WB'(elem(out_window, 0)), 0);
        chk("first_e4", WB'(elem(out_window, 4)), 4);
        chk("first_e20", WB'(elem(out_window, 20)), 32);
        chk("first_e24", WB'(elem(out_window, 24)), 36);
        for (int i = 37; i < 48; i++) push(DW'(i), 0);
        drain();
        chk("basic_count", WB'(wq.size()), 8);
        if (wq.size() == 8) begin
            check_frame("basic", 0);
            chk("basic_last_e24", WB'(elem(wq[7], 24)), 47);
        end

        // Backpressure on the first window
        wq.delete(); lq.delete();
        fork
            send_frame(0);
            begin
                int n;
                n = 0;
                do begin @(posedge clk); #1; n++; end while (!out_valid && n < 200);
                if (!out_valid) chk("bp_wait_timeout", 0, 1);
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready", WB'(in_ready), 0);
                    chk("bp_hold_e24", WB'(elem(out_window, 24)), 36);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", WB'(wq.size()), 8);
        if (wq.size() == 8) begin
            chk("bp_second_e24", WB'(elem(wq[1], 24)), 37);
            check_frame("bp", 0);
        end

        // Back-to-back frames
        wq.delete(); lq.delete();
        send_frame(0);
        send_frame(0);
        drain();
        chk("b2b_count", WB'(wq.size()), 16);
        if (wq.size() == 16) begin
            check_frame("b2b_f0", 0);
            check_frame("b2b_f1", 8);
            chk("b2b_first_equal", wq[8], wq[0]);
        end

        // Input bubbles
        wq.delete(); lq.delete();
        send_frame(1);
        drain();
        chk("bub_count", WB'(wq.size()), 8);
        if (wq.size() == 8) check_frame("bub", 0);

        // Reset mid-frame
        for (int i = 0; i <= 40; i++) push(DW'(i), 0);
        chk("pre_rst_window_nonzero", WB'(out_window != '0), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", WB'(out_valid), 0);
        chk("async_rst_out_window", out_window, 0);
        chk("async_rst_out_last", WB'(out_last), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        wq.delete(); lq.delete();
        for (int i = 0; i < 36; i++) push(DW'(i), 0);
        chk("rst_pre36_out_valid", WB'(out_valid), 0);
        push(6'd36, 0);
        chk("rst_post36_out_valid", WB'(out_valid), 1);
        chk("rst_first_e24", WB'(elem(out_window, 24)), 36);
        for (int i = 37; i < 48; i++) push(DW'(i), 0);
        drain();
        chk("rst_count", WB'(wq.size()), 8);
        if (wq.size() == 8) check_frame("rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
